// File: rtl/btn_word_loader_if.sv
// Consumer-side handshake bundle for btn_word_loader.
// Ports: o_data/o_valid driven by the loader, i_ready by the consumer.
interface btn_word_loader_if #(
   parameter int DATA_W = 48
);
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;

   modport master (
      output o_data,
      output o_valid,
      input  i_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      output i_ready
   );
endinterface

// File: rtl/btn_word_loader.sv
// Serial MSB-first word entry from bit pulses, committed into a FIFO.
// Ports: clk, ck_rstn, i_bit0/i_bit1/i_commit/i_clear pulses, bus (data/valid/ready),
// o_count bits assembled, o_level FIFO occupancy, sticky o_err_ovf/o_err_short/o_err_drop.
module btn_word_loader #(
   parameter int DATA_W    = 48,
   parameter int DEPTH     = 4,
   parameter bit PAD_SHORT = 1'b0,
   parameter int CNT_W     = $clog2(DATA_W+1)
) (
   input  logic                   clk,
   input  logic                   ck_rstn,
   input  logic                   i_bit0,
   input  logic                   i_bit1,
   input  logic                   i_commit,
   input  logic                   i_clear,
   btn_word_loader_if.master      bus,
   output logic [CNT_W-1:0]       o_count,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_err_ovf,
   output logic                   o_err_short,
   output logic                   o_err_drop
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_COLLECT = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [CNT_W-1:0]  count_q;
   logic              ovf_q;
   logic              short_q;
   logic              drop_q;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q;
   logic [AW:0]       rptr_q;
   logic [AW:0]       wptr_d;
   logic [AW:0]       rptr_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              push_req;
   logic              push_ok;
   logic              bit_one;
   logic              bit_both;
   logic [CNT_W-1:0]  pad_sh;
   logic [DATA_W-1:0] push_word;

   assign fifo_empty = (wptr_q == rptr_q);
   // Full: wrap bits differ, address bits match.
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign bit_one  = i_bit0 ^ i_bit1;
   assign bit_both = i_bit0 & i_bit1;

   // Left-align a short word by the number of missing bits.
   assign pad_sh    = CNT_W'(DATA_W) - count_q;
   assign push_word = (state_q == S_FULL) ? shreg_q : (shreg_q << pad_sh);

   assign push_req = i_commit && !i_clear &&
                     ((state_q == S_FULL) ||
                      ((state_q == S_COLLECT) && PAD_SHORT));

   // A push into a full FIFO is refused even if a pop happens this cycle.
   assign push_ok = push_req && !fifo_full;
   assign pop     = !fifo_empty && bus.i_ready && !i_clear;

   always_ff @(posedge clk or negedge ck_rstn) begin
      if (!ck_rstn) begin
         state_q <= S_EMPTY;
         shreg_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         short_q <= 1'b0;
         drop_q  <= 1'b0;
      end else if (i_clear) begin
         state_q <= S_EMPTY;
         shreg_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         short_q <= 1'b0;
         drop_q  <= 1'b0;
      end else if (i_commit) begin
         state_q <= S_EMPTY;
         shreg_q <= '0;
         count_q <= '0;
         if ((state_q == S_EMPTY) ||
             ((state_q == S_COLLECT) && !PAD_SHORT))
            short_q <= 1'b1;
         if (push_req && fifo_full)
            drop_q <= 1'b1;
      end else if (bit_both) begin
         drop_q <= 1'b1;
      end else if (bit_one) begin
         unique case (state_q)
            S_EMPTY, S_COLLECT: begin
               shreg_q <= {shreg_q[DATA_W-2:0], i_bit1};
               count_q <= count_q + 1'b1;
               if (count_q == CNT_W'(DATA_W-1))
                  state_q <= S_FULL;
               else
                  state_q <= S_COLLECT;
            end
            S_FULL:  ovf_q <= 1'b1;
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (i_clear) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop)     rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge ck_rstn) begin
      if (!ck_rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wptr_q[AW-1:0]] <= push_word;
   end

   // Head is read straight from storage; masked to zero while empty.
   assign bus.o_data  = fifo_empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign bus.o_valid = !fifo_empty;

   assign o_count     = count_q;
   assign o_level     = wptr_q - rptr_q;
   assign o_err_ovf   = ovf_q;
   assign o_err_short = short_q;
   assign o_err_drop  = drop_q;
endmodule
